// File: rtl/updown_mod_counter_if.sv
// Control/status bundle for updown_mod_counter.
// sat_mode exists only when UDC_SATURATE_EN is defined.
interface updown_mod_counter_if #(
   parameter int WIDTH = 8
);
   logic             en;
   logic             updown;
   logic             clear;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] max_val;
`ifdef UDC_SATURATE_EN
   logic             sat_mode;
`endif
   logic [WIDTH-1:0] count;
   logic             wrap;
   logic             at_max;
   logic             at_zero;

   modport master (
      output en, updown, clear, load, load_val, max_val,
`ifdef UDC_SATURATE_EN
      output sat_mode,
`endif
      input  count, wrap, at_max, at_zero
   );

   modport slave (
      input  en, updown, clear, load, load_val, max_val,
`ifdef UDC_SATURATE_EN
      input  sat_mode,
`endif
      output count, wrap, at_max, at_zero
   );
endinterface

// File: rtl/updown_mod_counter.sv
// Up/down counter with runtime modulus 0..max_val and wrap strobe.
// Optional saturation behaviour via UDC_SATURATE_EN.
module updown_mod_counter #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   updown_mod_counter_if.slave  bus
);
   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_nxt;
   logic             wrap_q;
   logic             wrap_nxt;
   logic             sat;

`ifdef UDC_SATURATE_EN
   assign sat = bus.sat_mode;
`else
   assign sat = 1'b0;
`endif

   always_comb begin
      count_nxt = count_q;
      wrap_nxt  = 1'b0;
      if (bus.clear) begin
         count_nxt = '0;
      end else if (bus.load) begin
         count_nxt = (bus.load_val > bus.max_val) ? bus.max_val
                                                  : bus.load_val;
      end else if (bus.en) begin
         // out-of-range count snaps to the bound, no arithmetic
         if (count_q > bus.max_val) begin
            count_nxt = bus.max_val;
         end else if (bus.updown) begin
            if (count_q == bus.max_val) begin
               if (!sat) begin
                  count_nxt = '0;
                  wrap_nxt  = 1'b1;
               end
            end else begin
               count_nxt = count_q + 1'b1;
            end
         end else begin
            if (count_q == '0) begin
               if (!sat) begin
                  count_nxt = bus.max_val;
                  wrap_nxt  = 1'b1;
               end
            end else begin
               count_nxt = count_q - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= RESET_VAL;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_nxt;
         wrap_q  <= wrap_nxt;
      end
   end

   assign bus.count   = count_q;
   assign bus.wrap    = wrap_q;
   assign bus.at_max  = (count_q == bus.max_val);
   assign bus.at_zero = (count_q == '0);
endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter, WIDTH=4, RESET_VAL=3.
// Saturation sequence runs when UDC_SATURATE_EN is defined.
module tb_updown_mod_counter;
   localparam int W = 4;

   typedef struct {
      logic         clear;
      logic         load;
      logic         en;
      logic         updown;
      logic [W-1:0] load_val;
      logic [W-1:0] max_val;
      logic [W-1:0] e_count;
      logic         e_wrap;
      logic         e_max;
      logic         e_zero;
   } vec_t;

   logic clk;
   logic reset_n;
   int   total;
   int   bad;
   vec_t vec [64];
   int   nv;

   updown_mod_counter_if #(.WIDTH(W)) bus ();

   updown_mod_counter #(
      .WIDTH(W),
      .RESET_VAL(4'd3)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic add(input logic c, input logic l, input logic e,
                      input logic u, input logic [W-1:0] lv,
                      input logic [W-1:0] mv, input logic [W-1:0] ec,
                      input logic ew, input logic em, input logic ez);
      vec[nv] = '{c, l, e, u, lv, mv, ec, ew, em, ez};
      nv++;
   endtask

   task automatic drive(input logic c, input logic l, input logic e,
                        input logic u, input logic [W-1:0] lv,
                        input logic [W-1:0] mv);
      bus.clear    = c;
      bus.load     = l;
      bus.en       = e;
      bus.updown   = u;
      bus.load_val = lv;
      bus.max_val  = mv;
   endtask

   task automatic step_chk(input string nm, input logic [W-1:0] ec,
                           input logic ew);
      @(posedge clk);
      #1;
      chk({nm, ".count"}, 32'(bus.count), 32'(ec));
      chk({nm, ".wrap"}, 32'(bus.wrap), 32'(ew));
   endtask

   initial begin
      total = 0;
      bad   = 0;
      nv    = 0;
      reset_n = 1'b0;
      drive(0, 0, 0, 1, 4'd0, 4'd9);
`ifdef UDC_SATURATE_EN
      bus.sat_mode = 1'b0;
`endif

      // table: clr ld en up lv mv -> count wrap at_max at_zero
      add(1, 0, 0, 1, 0, 9, 0, 0, 0, 1);
      for (int i = 1; i <= 9; i++)
         add(0, 0, 1, 1, 0, 9, 4'(i), 0, (i == 9), 0);
      add(0, 0, 1, 1, 0, 9, 0, 1, 0, 1);
      add(0, 0, 1, 1, 0, 9, 1, 0, 0, 0);
      add(0, 0, 1, 1, 0, 9, 2, 0, 0, 0);
      add(0, 0, 1, 0, 0, 9, 1, 0, 0, 0);
      add(0, 0, 1, 0, 0, 9, 0, 0, 0, 1);
      add(0, 0, 1, 0, 0, 9, 9, 1, 1, 0);
      add(0, 0, 1, 0, 0, 9, 8, 0, 0, 0);
      add(1, 1, 1, 1, 5, 9, 0, 0, 0, 1);
      add(0, 1, 1, 1, 12, 9, 9, 0, 1, 0);
      add(0, 1, 0, 1, 8, 9, 8, 0, 0, 0);
      add(0, 0, 1, 1, 0, 4, 4, 0, 1, 0);
      add(0, 0, 1, 1, 0, 0, 0, 0, 1, 1);
      add(0, 0, 1, 1, 0, 0, 0, 1, 1, 1);
      add(0, 0, 1, 1, 0, 0, 0, 1, 1, 1);
      add(0, 0, 1, 0, 0, 0, 0, 1, 1, 1);
      add(0, 0, 0, 0, 0, 9, 0, 0, 0, 1);
      add(0, 1, 0, 0, 5, 9, 5, 0, 0, 0);
      add(0, 0, 0, 1, 0, 9, 5, 0, 0, 0);
      add(0, 1, 0, 0, 8, 9, 8, 0, 0, 0);
      add(0, 0, 1, 0, 0, 3, 3, 0, 1, 0);
      add(0, 0, 1, 0, 0, 3, 2, 0, 0, 0);
      add(0, 0, 1, 1, 15, 15, 3, 0, 0, 0);

      // reset state
      #12;
      chk("rst.count", 32'(bus.count), 32'd3);
      chk("rst.wrap", 32'(bus.wrap), 32'd0);
      chk("rst.at_zero", 32'(bus.at_zero), 32'd0);
      chk("rst.at_max", 32'(bus.at_max), 32'd0);

      @(negedge clk);
      reset_n = 1'b1;
      bus.en  = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("pre_rst.count", 32'(bus.count), 32'd7);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst.count", 32'(bus.count), 32'd3);
      chk("async_rst.wrap", 32'(bus.wrap), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      bus.en  = 1'b0;

      for (int i = 0; i < nv; i++) begin
         @(negedge clk);
         drive(vec[i].clear, vec[i].load, vec[i].en, vec[i].updown,
               vec[i].load_val, vec[i].max_val);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d.count", i), 32'(bus.count),
             32'(vec[i].e_count));
         chk($sformatf("v%0d.wrap", i), 32'(bus.wrap),
             32'(vec[i].e_wrap));
         chk($sformatf("v%0d.at_max", i), 32'(bus.at_max),
             32'(vec[i].e_max));
         chk($sformatf("v%0d.at_zero", i), 32'(bus.at_zero),
             32'(vec[i].e_zero));
      end

`ifdef UDC_SATURATE_EN
      @(negedge clk);
      bus.sat_mode = 1'b1;
      drive(0, 1, 0, 1, 15, 15);
      step_chk("sat.load", 15, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive(0, 0, 1, 1, 0, 15);
         step_chk($sformatf("sat.up%0d", i), 15, 0);
      end
      @(negedge clk);
      drive(1, 0, 0, 0, 0, 15);
      step_chk("sat.clr", 0, 0);
      @(negedge clk);
      drive(0, 0, 1, 0, 0, 15);
      step_chk("sat.dn", 0, 0);
      @(negedge clk);
      bus.sat_mode = 1'b0;
      step_chk("nosat.dn", 15, 1);
`else
      @(negedge clk);
      drive(0, 1, 0, 1, 15, 15);
      step_chk("wrapmode.load", 15, 0);
      @(negedge clk);
      drive(0, 0, 1, 1, 0, 15);
      step_chk("wrapmode.up", 0, 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
